// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared widths and encodings for the memory responder
//
// Purpose: data/address widths, FSM state encoding and captured-operation
// type used by mem_responder.
// Ports: none (package).
package mem_responder_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 26;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - loadable 8-bit down-counter for wait-state insertion
//
// Purpose: counts wait states down to zero; saturates at zero.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset (count -> 0)
//   load   in   load value into the counter (has priority over enable)
//   enable in   decrement by one when non-zero
//   value  in   load value
//   zero   out  count is zero
module mem_wait_counter
  import mem_responder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated word memory with four-phase READY handshake
//
// Purpose: accepts single-word READ/WRITE requests, inserts WAIT_CYCLES wait
// states, performs the access on an internal array and holds READY until the
// request lines are withdrawn.
// Optional feature: define MEM_RESPONDER_BOUNDS_CHECK_EN to flag addresses
// >= DEPTH on ERR (write suppressed, read returns 0); otherwise upper address
// bits alias and ERR is tied 0.
// Ports:
//   CLK      in   clock, rising edge
//   RST      in   asynchronous active-high reset
//   READ     in   read request level
//   WRITE    in   write request level
//   ADDR     in   word address (26 bits)
//   DATA_IN  in   write data
//   DATA_OUT out  registered read data, holds last read value
//   READY    out  access complete, held until both request lines drop
//   BUSY     out  request accepted and not yet completed
//   ERR      out  out-of-range access flag (DONE phase only)
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] INIT_VALUE  = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              READY,
  output logic              BUSY,
  output logic              ERR
);

  // DEPTH must be at least 2 so the index has at least one bit.
  localparam int IDX_W = $clog2(DEPTH);
  localparam int WORDS = 1 << IDX_W;

  logic [DATA_W-1:0] mem [WORDS];

  state_t            state;
  op_t               cap_op;
  logic [IDX_W-1:0]  cap_idx;
  logic [DATA_W-1:0] cap_data;
  logic              cnt_zero;

  // Exactly one line high; both high is an illegal request and is ignored.
  logic req_single;
  // Only the line of the captured op keeps the transaction alive in WAIT.
  logic req_held;
  logic do_access;
  logic write_en;

  assign req_single = READ ^ WRITE;
  assign req_held   = (cap_op == OP_WRITE) ? WRITE : READ;
  assign do_access  = (state == ST_WAIT) && req_held && cnt_zero;

  mem_wait_counter u_wait_counter (
    .clk    (CLK),
    .rst    (RST),
    .load   ((state == ST_IDLE) && req_single),
    .enable ((state == ST_WAIT) && req_held),
    .value  (CNT_W'(WAIT_CYCLES)),
    .zero   (cnt_zero)
  );

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
  logic cap_oor;

  assign write_en = do_access && (cap_op == OP_WRITE) && !cap_oor;
`else
  // Upper address bits intentionally alias onto the array.
  logic unused_addr_hi;

  assign unused_addr_hi = ^ADDR[ADDR_W-1:IDX_W];
  assign write_en       = do_access && (cap_op == OP_WRITE);
  assign ERR            = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      READY    <= 1'b0;
      BUSY     <= 1'b0;
      DATA_OUT <= INIT_VALUE;
      cap_op   <= OP_READ;
      cap_idx  <= '0;
      cap_data <= '0;
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
      cap_oor  <= 1'b0;
      ERR      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_single) begin
            cap_op   <= WRITE ? OP_WRITE : OP_READ;
            cap_idx  <= ADDR[IDX_W-1:0];
            cap_data <= DATA_IN;
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
            cap_oor  <= (ADDR >= ADDR_W'(DEPTH));
`endif
            BUSY     <= 1'b1;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!req_held) begin
            BUSY  <= 1'b0;
            state <= ST_IDLE;
          end else if (cnt_zero) begin
            if (cap_op == OP_READ) begin
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
              DATA_OUT <= cap_oor ? '0 : mem[cap_idx];
`else
              DATA_OUT <= mem[cap_idx];
`endif
            end
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
            ERR   <= cap_oor;
`endif
            READY <= 1'b1;
            BUSY  <= 1'b0;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!READ && !WRITE) begin
            READY <= 1'b0;
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
            ERR   <= 1'b0;
`endif
            state <= ST_IDLE;
          end
        end
        default: begin
          READY <= 1'b0;
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Array is never reset; RST gating drops a write that coincides with reset.
  always_ff @(posedge CLK) begin
    if (write_en && !RST) begin
      mem[cap_idx] <= cap_data;
    end
  end

endmodule
